// File: rtl/cpu_sequencer.sv
// Timing-state generator for the accumulator CPU: one-hot FETCH/EXEC1/EXEC2
// strobes, run / single-step / halt control, illegal-opcode trap, and
// saturating instruction and cycle counters for debug.
module cpu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RUN,
    input  logic             STEP,
    input  logic             EXTRA,
    input  logic [3:0]       IR,
    output logic             FETCH,
    output logic             EXEC1,
    output logic             EXEC2,
    output logic             HALTED,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] INSTR_CNT,
    output logic [CNT_W-1:0] CYCLE_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC1,
        S_EXEC2,
        S_HALT,
        S_TRAP
    } state_t;

    localparam logic [3:0] OP_STP = 4'b0111;

    state_t state;
    state_t state_nxt;
    logic   ss;          // set while the current instruction was started by a step
    logic   ss_nxt;
    logic   step_q;
    logic   step_pulse;
    logic   eoi;         // last cycle of a completed instruction
    logic   active;      // a phase strobe is high this cycle

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Opcodes with no defined instruction behind them.
    function automatic logic is_illegal(input logic [3:0] op);
        case (op)
            4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b1111: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    assign step_pulse = STEP & ~step_q;
    assign active     = (state == S_FETCH) || (state == S_EXEC1) || (state == S_EXEC2);

    // Moore outputs: decoded from the state register only.
    assign FETCH   = (state == S_FETCH);
    assign EXEC1   = (state == S_EXEC1);
    assign EXEC2   = (state == S_EXEC2);
    assign HALTED  = (state == S_HALT) || (state == S_TRAP);
    assign ILLEGAL = (state == S_TRAP);

    // State, single-step flag and step edge detector registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= S_IDLE;
            ss     <= 1'b0;
            step_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ss     <= ss_nxt;
            step_q <= STEP;
        end
    end

    // Next-state logic; RUN is only looked at in IDLE and at end of instruction.
    always_comb begin
        state_nxt = state;
        ss_nxt    = ss;
        eoi       = 1'b0;
        case (state)
            S_IDLE: begin
                if (RUN) begin
                    state_nxt = S_FETCH;
                    ss_nxt    = 1'b0;
                end else if (step_pulse) begin
                    state_nxt = S_FETCH;
                    ss_nxt    = 1'b1;
                end
            end
            S_FETCH: state_nxt = S_EXEC1;
            S_EXEC1: begin
                if (IR == OP_STP)
                    state_nxt = S_HALT;
                else if (is_illegal(IR))
                    state_nxt = S_TRAP;
                else if (EXTRA)
                    state_nxt = S_EXEC2;
                else
                    eoi = 1'b1;
            end
            S_EXEC2: eoi = 1'b1;
            S_HALT:  state_nxt = S_HALT;
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_IDLE;
        endcase
        // A stepped instruction always returns to IDLE, even with RUN high.
        if (eoi)
            state_nxt = (RUN && !ss) ? S_FETCH : S_IDLE;
    end

    // Debug counters: completed instructions and active phase cycles.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            INSTR_CNT <= '0;
            CYCLE_CNT <= '0;
        end else begin
            if (eoi)
                INSTR_CNT <= sat_inc(INSTR_CNT);
            if (active)
                CYCLE_CNT <= sat_inc(CYCLE_CNT);
        end
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Timing-state generator for the accumulator CPU. Produces the one-hot FETCH/EXEC1/EXEC2 phase strobes that feed the instruction decoder.
- Adds run / single-step / halt control, an illegal-opcode trap, and saturating instruction and cycle counters for debug.
- Sits between the board control inputs and the decoder. Consumes the decoder's EXTRA output and the current IR opcode.

Parameters:
- CNT_W, 16, width of INSTR_CNT and CYCLE_CNT.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RUN  in  1  level; 1 = free-run instructions back to back.
- STEP  in  1  level from a debounced button; a rising edge requests one instruction.
- EXTRA  in  1  from decoder; 1 during EXEC1 means the instruction needs EXEC2.
- IR  in  4  current opcode; valid from EXEC1 onward.
- FETCH  out  1  fetch phase strobe; also serves as the IR load enable.
- EXEC1  out  1  first execute phase.
- EXEC2  out  1  second execute phase.
- HALTED  out  1  sticky; set by STP or by an illegal opcode.
- ILLEGAL  out  1  sticky; set by an illegal opcode.
- INSTR_CNT  out  CNT_W  completed instructions, saturating.
- CYCLE_CNT  out  CNT_W  cycles spent in FETCH/EXEC1/EXEC2, saturating.

Behaviour:
- Clocking and reset: one clock, CLK. RESET is asynchronous, active-high.
  - Reset forces state IDLE immediately, with no clock edge needed.
  - All outputs go to 0. The step edge-detector register clears to 0.
- Outputs are Moore: FETCH/EXEC1/EXEC2/HALTED/ILLEGAL decode only from the state register. No input reaches them combinationally.
- At most one phase strobe is high in any cycle.
- In IDLE, HALT and TRAP all strobes are 0, so decoder outputs are inactive and the PC and ACC are frozen.
- step_pulse = STEP & !step_q, where step_q is STEP registered every cycle in all states.
- States: IDLE, FETCH, EXEC1, EXEC2, HALT, TRAP.
- IDLE transitions:
  - RUN=1 -> FETCH, single-step flag ss=0.
  - else step_pulse -> FETCH, ss=1.
  - else stay in IDLE.
  - RUN has priority over STEP.
- FETCH -> EXEC1, unconditionally.
- EXEC1 transitions, in priority order:
  - IR=0111 (STP) -> HALT.
  - IR in {1001, 1100, 1101, 1110, 1111} -> TRAP.
  - EXTRA=1 -> EXEC2.
  - otherwise end-of-instruction (EOI).
- EXEC2 -> EOI.
- EOI:
  - INSTR_CNT increments.
  - Next state is FETCH if RUN=1 and ss=0, else IDLE.
  - RUN is sampled only at EOI. An instruction in progress always completes, even if RUN falls mid-instruction.
  - If RUN=1 at EOI with ss=1, the next state is IDLE; the following IDLE cycle then starts free-run.
- HALT:
  - HALTED=1.
  - Sticky until RESET. RUN and STEP are ignored.
  - STP does not increment INSTR_CNT.
- TRAP:
  - HALTED=1 and ILLEGAL=1.
  - Sticky until RESET.
  - No INSTR_CNT increment.
- STEP edges arriving outside IDLE are discarded, not queued.
- CYCLE_CNT:
  - +1 on each cycle whose state is FETCH, EXEC1 or EXEC2.
  - Holds in IDLE, HALT and TRAP.
- Both counters saturate at 2^CNT_W-1; they never wrap.
- Latency:
  - First FETCH is 1 cycle after RUN is sampled high in IDLE.
  - An instruction takes 2 cycles if EXTRA=0 and 3 cycles if EXTRA=1.
  - HALTED asserts on the cycle after the EXEC1 that saw STP.

Test Plan:
- Reset, RUN=1, IR=0000 (LDA), EXTRA=1 in EXEC1 -> strobes cycle FETCH, EXEC1, EXEC2, FETCH, ... ; INSTR_CNT=1 and CYCLE_CNT=3 after the first EOI; INSTR_CNT=3 after 9 active cycles.
- RUN=0, IR=0100 (JMP), EXTRA=0, STEP held high 10 cycles -> exactly FETCH, EXEC1, then IDLE; INSTR_CNT=1, CYCLE_CNT=2; a second STEP rising edge -> INSTR_CNT=2.
- RUN=1, IR=0111 in EXEC1 -> HALTED=1 next cycle, all strobes 0, INSTR_CNT unchanged; toggling RUN and STEP for 20 cycles -> no change; RESET -> HALTED=0, state IDLE.
- RUN=1, IR=1001 in EXEC1 -> ILLEGAL=1, HALTED=1, strobes 0; IR=1010 (LSR) with EXTRA=0 -> normal 2-cycle instruction, no trap.
- RUN=1, LDA with EXTRA=1, RUN dropped during EXEC1 -> EXEC2 still asserted, then IDLE with INSTR_CNT incremented by 1; RUN and STEP rising in the same IDLE cycle -> free-run (ss=0).
- RESET asserted mid-EXEC2 with no clock edge -> all outputs 0 within the same cycle. With CNT_W=4 and 20 instructions run -> INSTR_CNT=15 and CYCLE_CNT=15, both held.
